avalon_mem_slave: RTL and testbench
===================================

Name: avalon_mem_slave

Overview:
- Parametrised Avalon-MM slave memory model for the Avalon example benches and for standalone simulation of Avalon masters.
- Programmable wait-state insertion through waitrequest.
- Pipelined reads with fixed READ_LATENCY; multiple outstanding reads allowed.
- Byte-enabled writes, sticky protocol-error detection, and accepted-transaction counters for bench checking.

Parameters:
DATA_W, 32, data width in bits; multiple of 8
ADDR_W, 4, word address width; DEPTH = 2**ADDR_W words
WAIT_CYCLES, 2, waitrequest-high cycles before each acceptance; 0 = zero-wait
READ_LATENCY, 1, cycles from the read-accept edge to readdatavalid; range 1..8
CNT_W, 16, width of the transaction counters

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
address  in  ADDR_W  word address
read  in  1  read request
write  in  1  write request
writedata  in  DATA_W  write data
byteenable  in  DATA_W/8  per-byte write enable
waitrequest  out  1  high = request not accepted this cycle
readdata  out  DATA_W  read data
readdatavalid  out  1  readdata valid this cycle
protocol_error  out  1  sticky error flag
rd_count  out  CNT_W  number of accepted reads
wr_count  out  CNT_W  number of accepted writes

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - stall counter = 0; latency pipeline cleared.
  - readdatavalid = 0; readdata = 0; protocol_error = 0; rd_count = wr_count = 0.
  - Memory contents are not reset.
- req = read | write.
- waitrequest = !(req && stall_cnt == WAIT_CYCLES). It is combinational from the inputs and stall_cnt. It is 1 when idle.
- stall_cnt behaviour:
  - Increments each cycle that req && waitrequest.
  - Returns to 0 on acceptance (req && !waitrequest).
  - Returns to 0 when req drops before acceptance.
  - Saturates at WAIT_CYCLES.
- WAIT_CYCLES = 0: every request is accepted in its first cycle; back-to-back transfers run at one per clock.
- Write accept: at that edge, memory bytes with byteenable[i] = 1 are updated; all other bytes keep their values. wr_count increments.
- byteenable = 0 on a write: the transfer is accepted and counted, and memory is unchanged.
- Read accept: at that edge, mem[address] is sampled into pipeline stage 1. rd_count increments.
- readdatavalid is high for exactly one cycle, READ_LATENCY cycles after the accept edge. readdata carries that word during that cycle.
- Ordering: read data returns in accept order. Up to READ_LATENCY reads may be in flight.
- Outside valid cycles, readdata holds its last valid value.
- Read-after-write: a read accepted one or more cycles after a write to the same address returns the new data.
- Simultaneous read & write asserted in the same cycle:
  - protocol_error sets (sticky until reset).
  - The write takes priority: only the write is performed and counted. No read data is returned.
- Request inputs changing while waitrequest is high: no error flagged. The stall counter continues while req stays high.
- Counters wrap modulo 2**CNT_W.
- Address range covers the full space; no out-of-range case exists.
- Reset mid-operation: in-flight reads are discarded and no readdatavalid is produced afterward. A write whose accept edge precedes reset assertion is kept.

Decomposition:
- Shared package avalon_pkg:
  - localparams for the maximum READ_LATENCY (8).
  - Byte-lane count function DATA_W/8.
  - clog2 helper used for the stall counter width.
- Sub-module avalon_rd_pipe: READ_LATENCY-deep valid+data shift register, asynchronously reset, producing readdatavalid/readdata.
- Memory array, stall counter, counters and error flag stay in the top level.

Test Plan:
- Defaults (WAIT_CYCLES = 2): write addr 3 data 0xDEADBEEF, byteenable = 4'hF, read held high -> waitrequest high for 2 cycles, low on the 3rd. Read of addr 3 -> readdatavalid exactly 1 cycle after accept, readdata = 0xDEADBEEF. wr_count = 1, rd_count = 1.
- Byte enables: write 0xFFFFFFFF to addr 5, then write 0x00000000 with byteenable = 4'b0101 -> read of addr 5 returns 0xFF00FF00.
- WAIT_CYCLES = 0, READ_LATENCY = 3: write 8 addresses, then issue 8 back-to-back reads on consecutive clocks -> waitrequest never high. readdatavalid is high for 8 consecutive cycles starting 3 cycles after the first accept, with data in order.
- Drive read = write = 1 at addr 2, writedata 0x11 -> protocol_error = 1 and stays 1. mem[2] = 0x11. wr_count +1, rd_count unchanged, no readdatavalid.
- READ_LATENCY = 4: accept a read, assert reset 2 cycles later -> readdatavalid never asserts. After reset, counters = 0, memory is intact (readback matches prior writes).
- CNT_W = 4: perform 17 writes -> wr_count = 1 (wrap).

Source files
------------

// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-MM slave memory model.
//   MAX_READ_LATENCY : deepest read pipeline the slave supports
//   byte_lanes()     : number of byte lanes for a given data width
//   clog2()          : ceiling log2, used to size the stall counter
package avalon_pkg;

    localparam int unsigned MAX_READ_LATENCY = 8;

    function automatic int unsigned byte_lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/avalon_rd_pipe.sv
// Read-return pipeline: LATENCY stages of valid+data. A word entering on
// i_valid leaves on o_valid exactly LATENCY clocks later. Each stage only
// reloads its data when a valid word arrives, so o_data holds the last
// returned word between valid cycles.
//   i_clock  : rising-edge clock
//   i_reset  : asynchronous active-high reset, clears valids and data
//   i_valid  : read accepted this cycle
//   i_data   : word sampled from memory at the accept edge
//   o_valid  : readdatavalid
//   o_data   : readdata
module avalon_rd_pipe
    import avalon_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    if (LATENCY < 1 || LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("avalon_rd_pipe: LATENCY out of range");
    end

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        logic              w_in_vld;
        logic [DATA_W-1:0] w_in_dat;
        logic              r_vld;
        logic [DATA_W-1:0] r_dat;

        if (g == 0) begin : g_head
            assign w_in_vld = i_valid;
            assign w_in_dat = i_data;
        end else begin : g_tail
            assign w_in_vld = g_stage[g-1].r_vld;
            assign w_in_dat = g_stage[g-1].r_dat;
        end

        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
                r_vld <= 1'b0;
                r_dat <= '0;
            end else begin
                r_vld <= w_in_vld;
                if (w_in_vld) begin
                    r_dat <= w_in_dat;
                end
            end
        end
    end

    assign o_valid = g_stage[LATENCY-1].r_vld;
    assign o_data  = g_stage[LATENCY-1].r_dat;

endmodule

// File: rtl/avalon_mem_slave.sv
// Avalon-MM slave memory model with programmable wait states, pipelined
// fixed-latency reads, byte-enabled writes, a sticky protocol-error flag
// and accepted-transaction counters.
//   clock          : rising-edge clock
//   reset          : asynchronous active-high reset (memory is not cleared)
//   address        : word address
//   read / write   : request strobes; both at once is a protocol error
//   writedata      : write data
//   byteenable     : per-byte write enable
//   waitrequest    : high = request not accepted this cycle
//   readdata       : read data, holds the last returned word
//   readdatavalid  : readdata valid this cycle
//   protocol_error : sticky, set by simultaneous read and write
//   rd_count       : accepted reads, wraps
//   wr_count       : accepted writes, wraps
module avalon_mem_slave
    import avalon_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    output logic                waitrequest,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                protocol_error,
    output logic [CNT_W-1:0]    rd_count,
    output logic [CNT_W-1:0]    wr_count
);

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned NUM_LANES = byte_lanes(DATA_W);
    localparam int unsigned STALL_W   = (clog2(WAIT_CYCLES + 1) > 0) ?
                                        clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(WAIT_CYCLES);

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("avalon_mem_slave: DATA_W must be a multiple of 8");
    end

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_proto_err;
    logic [CNT_W-1:0]   r_rd_count;
    logic [CNT_W-1:0]   r_wr_count;

    logic               w_req;
    logic               w_accept;
    logic               w_wr_accept;
    logic               w_rd_accept;
    logic [DATA_W-1:0]  w_rd_word;

    assign w_req       = read | write;
    assign waitrequest = !(w_req && (r_stall_cnt == STALL_MAX));
    assign w_accept    = w_req && !waitrequest;
    // A write wins over a simultaneous read; the read is dropped entirely.
    assign w_wr_accept = w_accept && write;
    assign w_rd_accept = w_accept && read && !write;
    assign w_rd_word   = r_mem[address];

    // Counts cycles the current request has been stalled; any gap in the
    // request restarts the wait from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!w_req || w_accept) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt != STALL_MAX) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clock) begin
        if (w_wr_accept) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (byteenable[i]) begin
                    r_mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_proto_err <= 1'b0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
        end else begin
            if (read && write) begin
                r_proto_err <= 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
            if (w_wr_accept) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    avalon_rd_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .i_clock (clock),
        .i_reset (reset),
        .i_valid (w_rd_accept),
        .i_data  (w_rd_word),
        .o_valid (readdatavalid),
        .o_data  (readdata)
    );

    assign protocol_error = r_proto_err;
    assign rd_count       = r_rd_count;
    assign wr_count       = r_wr_count;

endmodule

// File: tb/tb_avalon_mem_slave.sv
`timescale 1ns/1ps
// Two slaves share clock and reset: A uses WAIT_CYCLES=2, READ_LATENCY=1,
// CNT_W=16; B uses WAIT_CYCLES=0, READ_LATENCY=3, CNT_W=4. A transaction
// level reference model (memory array, return queue with due cycles,
// counters) predicts every output on every cycle.
module tb_avalon_mem_slave;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rd [2];
    logic        wr [2];
    logic [3:0]  adr [2];
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic        wreq [2];
    logic        rvld [2];
    logic        perr [2];
    logic [31:0] rdat [2];
    logic [15:0] rc_a, wc_a;
    logic [3:0]  rc_b, wc_b;
    logic [15:0] rc [2];
    logic [15:0] wc [2];

    assign rc[0] = rc_a;
    assign wc[0] = wc_a;
    assign rc[1] = {12'h000, rc_b};
    assign wc[1] = {12'h000, wc_b};

    avalon_mem_slave #(
        .DATA_W(32), .ADDR_W(4), .WAIT_CYCLES(2), .READ_LATENCY(1), .CNT_W(16)
    ) u_dut_a (
        .clock(clk), .reset(rst), .address(adr[0]), .read(rd[0]), .write(wr[0]),
        .writedata(wd[0]), .byteenable(be[0]), .waitrequest(wreq[0]),
        .readdata(rdat[0]), .readdatavalid(rvld[0]), .protocol_error(perr[0]),
        .rd_count(rc_a), .wr_count(wc_a)
    );

    avalon_mem_slave #(
        .DATA_W(32), .ADDR_W(4), .WAIT_CYCLES(0), .READ_LATENCY(3), .CNT_W(4)
    ) u_dut_b (
        .clock(clk), .reset(rst), .address(adr[1]), .read(rd[1]), .write(wr[1]),
        .writedata(wd[1]), .byteenable(be[1]), .waitrequest(wreq[1]),
        .readdata(rdat[1]), .readdatavalid(rvld[1]), .protocol_error(perr[1]),
        .rd_count(rc_b), .wr_count(wc_b)
    );

    // Reference model state
    logic [31:0] mem_m [2][16];
    int          held_m [2];     // cycles the current request has waited
    int unsigned rcnt_m [2];
    int unsigned wcnt_m [2];
    bit          err_m [2];
    logic [31:0] last_m [2];
    logic [31:0] q_dat [2][8];
    int          q_due [2][8];
    int          q_head [2];
    int          q_n [2];
    bit          acc_m [2];
    int          n_vld [2];
    int          cyc;

    int n_checks = 0;
    int n_errors = 0;

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int unsigned mask_of(input int k);
        return (k == 0) ? 32'hFFFF : 32'h000F;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model
    // for the coming rising edge, return #1 after that edge.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bit req;
            bit exp_wait;
            bit exp_vld;
            req      = rd[k] | wr[k];
            exp_wait = !(req && held_m[k] == wait_of(k));
            exp_vld  = (q_n[k] > 0) && (q_due[k][q_head[k]] == cyc);
            if (exp_vld) begin
                last_m[k] = q_dat[k][q_head[k]];
                q_head[k] = (q_head[k] + 1) % 8;
                q_n[k]--;
            end
            n_vld[k] += int'(rvld[k]);
            check($sformatf("waitrequest[%0d]", k), wreq[k], exp_wait);
            check($sformatf("readdatavalid[%0d]", k), rvld[k], exp_vld);
            check($sformatf("readdata[%0d]", k), rdat[k], last_m[k]);
            check($sformatf("protocol_error[%0d]", k), perr[k], err_m[k]);
            check($sformatf("rd_count[%0d]", k), rc[k], rcnt_m[k] & mask_of(k));
            check($sformatf("wr_count[%0d]", k), wc[k], wcnt_m[k] & mask_of(k));

            if (rd[k] && wr[k]) err_m[k] = 1'b1;
            acc_m[k] = req && !exp_wait;
            if (acc_m[k] && wr[k]) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[k][i]) mem_m[k][adr[k]][i*8 +: 8] = wd[k][i*8 +: 8];
                end
                wcnt_m[k]++;
            end else if (acc_m[k] && rd[k]) begin
                q_dat[k][(q_head[k] + q_n[k]) % 8] = mem_m[k][adr[k]];
                q_due[k][(q_head[k] + q_n[k]) % 8] = cyc + lat_of(k);
                q_n[k]++;
                rcnt_m[k]++;
            end
            if (!req || acc_m[k]) held_m[k] = 0;
            else if (held_m[k] < wait_of(k)) held_m[k]++;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0;
            wr[k] = 1'b0;
        end
        repeat (n) step();
    endtask

    // Hold one request on slave k until the model says it is accepted.
    task automatic xfer(input int k, input bit r, input bit w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] b, output int n_cyc);
        rd[k] = r; wr[k] = w; adr[k] = a; wd[k] = d; be[k] = b;
        n_cyc = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            n_cyc++;
            if (acc_m[k]) break;
        end
        rd[k] = 1'b0;
        wr[k] = 1'b0;
    endtask

    // Asserted asynchronously, one time unit after a rising edge.
    task automatic apply_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; adr[k] = '0; wd[k] = '0; be[k] = '0;
            held_m[k] = 0; rcnt_m[k] = 0; wcnt_m[k] = 0; err_m[k] = 1'b0;
            last_m[k] = '0; q_head[k] = 0; q_n[k] = 0; acc_m[k] = 1'b0;
        end
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rst_wait[%0d]", k), wreq[k], 1'b1);
                check($sformatf("rst_vld[%0d]", k), rvld[k], 1'b0);
                check($sformatf("rst_rdata[%0d]", k), rdat[k], 32'h0);
                check($sformatf("rst_err[%0d]", k), perr[k], 1'b0);
                check($sformatf("rst_rc[%0d]", k), rc[k], 16'h0);
                check($sformatf("rst_wc[%0d]", k), wc[k], 16'h0);
            end
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_cyc;
        int vld_before;
        cyc = 0;
        n_vld[0] = 0;
        n_vld[1] = 0;
        apply_reset();

        // Give every word a known value before anything reads it.
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 16; a++) begin
                xfer(k, 1'b0, 1'b1, 4'(a), $urandom, 4'hF, n_cyc);
            end
        end

        // A: two stall cycles then acceptance; read returns one cycle later.
        xfer(0, 1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF, n_cyc);
        check("a_write_wait_cycles", n_cyc, 3);
        xfer(0, 1'b1, 1'b0, 4'd3, 32'h0, 4'h0, n_cyc);
        check("a_read_wait_cycles", n_cyc, 3);
        idle(1);
        check("a_read_deadbeef", rdat[0], 32'hDEADBEEF);
        check("a_wr_count_17", wc_a, 16'd17);
        check("a_rd_count_1", rc_a, 16'd1);

        // A: byte enables.
        xfer(0, 1'b0, 1'b1, 4'd5, 32'hFFFFFFFF, 4'hF, n_cyc);
        xfer(0, 1'b0, 1'b1, 4'd5, 32'h00000000, 4'b0101, n_cyc);
        xfer(0, 1'b0, 1'b1, 4'd5, 32'h12345678, 4'b0000, n_cyc);
        xfer(0, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0, n_cyc);
        idle(1);
        check("a_byteenable", rdat[0], 32'hFF00FF00);

        // B: eight back-to-back reads, one per clock.
        vld_before = n_vld[1];
        for (int i = 0; i < 8; i++) begin
            rd[1] = 1'b1;
            adr[1] = 4'(i);
            step();
            check("b_burst_accept", acc_m[1], 1'b1);
        end
        idle(4);
        check("b_burst_valids", n_vld[1] - vld_before, 8);
        check("b_burst_last", rdat[1], mem_m[1][7]);

        // A: read and write together -> write wins, sticky error.
        xfer(0, 1'b1, 1'b1, 4'd2, 32'h11, 4'hF, n_cyc);
        idle(3);
        check("a_proto_err", perr[0], 1'b1);
        xfer(0, 1'b1, 1'b0, 4'd2, 32'h0, 4'h0, n_cyc);
        idle(1);
        check("a_proto_mem", rdat[0], 32'h11);
        check("a_proto_err_sticky", perr[0], 1'b1);

        // Randomised traffic on both slaves.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!((rd[k] || wr[k]) && !acc_m[k] && $urandom_range(3) != 0)) begin
                    int op;
                    op = int'($urandom_range(15));
                    rd[k]  = (op < 6) || (op == 15);
                    wr[k]  = (op >= 6 && op < 12) || (op == 15);
                    adr[k] = 4'($urandom_range(15));
                    wd[k]  = $urandom;
                    be[k]  = 4'($urandom_range(15));
                end
            end
            step();
        end
        idle(5);

        // B: reset with a read in flight discards it; memory survives.
        xfer(1, 1'b1, 1'b0, 4'd4, 32'h0, 4'h0, n_cyc);
        idle(1);
        vld_before = n_vld[1];
        apply_reset();
        idle(6);
        check("b_reset_no_vld", n_vld[1] - vld_before, 0);
        check("b_reset_rc", rc_b, 4'd0);
        check("b_reset_wc", wc_b, 4'd0);
        for (int a = 0; a < 16; a++) begin
            xfer(1, 1'b1, 1'b0, 4'(a), 32'h0, 4'h0, n_cyc);
        end
        idle(4);
        check("b_mem_intact", rdat[1], mem_m[1][15]);
        xfer(0, 1'b1, 1'b0, 4'd2, 32'h0, 4'h0, n_cyc);
        idle(1);
        check("a_mem_intact", rdat[0], mem_m[0][2]);

        // B: 4-bit write counter wraps after 16.
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            xfer(1, 1'b0, 1'b1, 4'(i), $urandom, 4'hF, n_cyc);
        end
        idle(1);
        check("b_wr_count_wrap", wc_b, 4'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
